// File: rtl/grid_cursor.sv
// grid_cursor: grid cell cursor with synchronised button edges, frame-aligned commit and registered VGA overlay
module grid_cursor #(
  parameter int GRID_COLS = 7,
  parameter int GRID_ROWS = 7,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int POS_W = 4,
  parameter int START_X = 3,
  parameter int START_Y = 4,
  parameter int WRAP = 0,
  parameter logic [2:0] COLOR = 3'b100
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [10:0]      iReadCol,
  input  logic [9:0]       iReadRow,
  input  logic             iFrameStart,
  input  logic             button_up,
  input  logic             button_down,
  input  logic             button_left,
  input  logic             button_right,
  output logic [POS_W-1:0] oPosX,
  output logic [POS_W-1:0] oPosY,
  output logic [2:0]       RGB_out,
  output logic             show_square,
  output logic             oMoved
);
  localparam int CELL_W = H_RES / GRID_COLS;
  localparam int CELL_H = V_RES / GRID_ROWS;
  localparam logic [POS_W-1:0] X_MAX = POS_W'(GRID_COLS - 1);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(GRID_ROWS - 1);
  localparam logic [10:0] CW = 11'(CELL_W);
  localparam logic [10:0] XL_MAX = 11'((GRID_COLS - 1) * CELL_W);
  localparam logic [10:0] XL_0 = 11'(START_X * CELL_W);
  localparam logic [9:0] CH = 10'(CELL_H);
  localparam logic [9:0] YL_MAX = 10'((GRID_ROWS - 1) * CELL_H);
  localparam logic [9:0] YL_0 = 10'(START_Y * CELL_H);
  localparam bit WR = WRAP != 0;

  typedef enum logic [1:0] {P_NONE, P_MINUS, P_PLUS} pend_t;

  logic [3:0] s1, s2, prev, edges;
  pend_t pend_x, pend_y, ex, ey;
  logic [POS_W-1:0] nx_x, nx_y;
  logic [10:0] x_lo, x_hi, nx_xlo;
  logic [9:0] y_lo, y_hi, nx_ylo;
  logic hit;

  function automatic logic [POS_W-1:0] step_pos(pend_t p, logic [POS_W-1:0] v, logic [POS_W-1:0] mx);
    return p == P_MINUS ? (v == '0 ? (WR ? mx : v) : v - POS_W'(1))
         : p == P_PLUS  ? (v == mx ? (WR ? '0 : v) : v + POS_W'(1)) : v;
  endfunction

  assign edges = s2 & ~prev;

  // Bounds follow the position transition: wraps reload, ordinary steps add or subtract one cell.
  always_comb begin
    ey = edges[0] ^ edges[1] ? (edges[0] ? P_MINUS : P_PLUS) : P_NONE;
    ex = edges[2] ^ edges[3] ? (edges[2] ? P_MINUS : P_PLUS) : P_NONE;
    nx_x = step_pos(pend_x, oPosX, X_MAX);
    nx_y = step_pos(pend_y, oPosY, Y_MAX);
    nx_xlo = nx_x == oPosX ? x_lo
           : (nx_x == '0 && oPosX == X_MAX) ? 11'd0
           : (nx_x == X_MAX && oPosX == '0) ? XL_MAX
           : pend_x == P_MINUS ? x_lo - CW : x_lo + CW;
    nx_ylo = nx_y == oPosY ? y_lo
           : (nx_y == '0 && oPosY == Y_MAX) ? 10'd0
           : (nx_y == Y_MAX && oPosY == '0) ? YL_MAX
           : pend_y == P_MINUS ? y_lo - CH : y_lo + CH;
    hit = iReadCol >= x_lo && iReadCol < x_hi && iReadRow >= y_lo && iReadRow < y_hi;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1 <= '1;
      s2 <= '1;
      prev <= '1;
      pend_x <= P_NONE;
      pend_y <= P_NONE;
      oPosX <= POS_W'(START_X);
      oPosY <= POS_W'(START_Y);
      x_lo <= XL_0;
      x_hi <= XL_0 + CW;
      y_lo <= YL_0;
      y_hi <= YL_0 + CH;
      show_square <= 1'b0;
      RGB_out <= 3'b000;
      oMoved <= 1'b0;
    end else begin
      s1 <= {button_right, button_left, button_down, button_up};
      s2 <= s1;
      prev <= s2;
      pend_x <= (iFrameStart || ex != P_NONE) ? ex : pend_x;
      pend_y <= (iFrameStart || ey != P_NONE) ? ey : pend_y;
      oMoved <= iFrameStart && (nx_x != oPosX || nx_y != oPosY);
      if (iFrameStart) begin
        oPosX <= nx_x;
        oPosY <= nx_y;
        x_lo <= nx_xlo;
        x_hi <= nx_xlo + CW;
        y_lo <= nx_ylo;
        y_hi <= nx_ylo + CH;
      end
      show_square <= hit;
      RGB_out <= hit ? COLOR : 3'b000;
    end
  end
endmodule

// File: doc/grid_cursor.md
Name: grid_cursor

Overview:
- Parametrised successor of the single red-square mover: a synchronous cursor controller that tracks one highlighted cell on a GRID_COLS x GRID_ROWS board overlaid on the VGA raster.
- Takes move pulses from the PS/2 keyboard decoder or the push buttons, synchronises and edge-detects them, and buffers one pending move per axis.
- Commits buffered moves only at frame start, so the cursor never tears mid-frame.
- Drives a registered show_square/RGB overlay into the background mux in the top level.

Parameters:
- GRID_COLS, 7, number of cell columns (2..16)
- GRID_ROWS, 7, number of cell rows (2..16)
- H_RES, 640, visible pixels per line
- V_RES, 480, visible lines per frame
- POS_W, 4, width of position outputs; must satisfy 2^POS_W >= max(GRID_COLS, GRID_ROWS)
- START_X, 3, column after reset
- START_Y, 4, row after reset
- WRAP, 0, edge mode: 0 = clamp at the border, 1 = wrap to the opposite edge
- COLOR, 3'b100, RGB value driven while the cursor is shown

Ports:
- Clock  in  1  system clock (25 MHz pixel clock)
- Reset  in  1  synchronous, active-high reset
- iReadCol  in  11  current pixel column from VH_GENERATOR
- iReadRow  in  10  current line from VH_GENERATOR
- iFrameStart  in  1  one-cycle pulse at the start of vertical blanking
- button_up  in  1  move request, asynchronous level
- button_down  in  1  move request, asynchronous level
- button_left  in  1  move request, asynchronous level
- button_right  in  1  move request, asynchronous level
- oPosX  out  POS_W  committed column
- oPosY  out  POS_W  committed row
- RGB_out  out  3  COLOR while show_square=1, else 3'b000
- show_square  out  1  current pixel lies inside the cursor cell
- oMoved  out  1  one-cycle pulse when a commit changes position

Behaviour:
- Reset is synchronous, active-high, with one clock (Clock) for the whole block.
- Derived constants: CELL_W = H_RES/GRID_COLS and CELL_H = V_RES/GRID_ROWS (integer division). Pixels past GRID_COLS*CELL_W or GRID_ROWS*CELL_H never belong to any cell.
- Input conditioning, per button: 2-FF synchronizer followed by a previous-value register.
  - Edge = sync2 & ~prev.
  - All three registers reset to 1, so a button held across reset release produces no move.
- Pending buffer, per axis: encodes none, minus or plus.
  - An up edge sets Y to minus; a down edge sets Y to plus. Left and right set X the same way.
  - Opposite edges in the same cycle leave that axis's pending value unchanged.
  - A newer edge overwrites an older pending value (latest wins). Only one cell is moved per axis per frame.
- Commit happens on the cycle iFrameStart=1.
  - Minus at 0: stays 0 if WRAP=0; goes to GRID_COLS-1 (or GRID_ROWS-1) if WRAP=1.
  - Plus at max: stays at max if WRAP=0; goes to 0 if WRAP=1.
  - Otherwise the position moves by ±1.
  - Pending is cleared on commit.
  - An edge arriving in the same cycle as iFrameStart is not applied; it becomes the new pending value.
- Bounds registers x_lo, x_hi, y_lo, y_hi are updated in the commit cycle alongside the position.
  - Updates are incremental (±CELL_W, ±CELL_H), with reload to 0 or (N-1)*CELL on wrap. No multipliers.
  - Invariant: x_lo = oPosX*CELL_W and x_hi = x_lo + CELL_W; y_lo and y_hi follow the same rule with CELL_H.
- oMoved: high for exactly the cycle after a commit in which oPosX or oPosY changed. Low when a clamp suppressed the move.
- Overlay:
  - show_square is registered, 1-cycle latency: show_square(t+1) = (x_lo <= iReadCol < x_hi) && (y_lo <= iReadRow < y_hi) at t.
  - RGB_out is registered alongside it.
  - The top level delays its template path by 1 cycle to align.
- Reset values: oPosX = START_X, oPosY = START_Y, bounds consistent with the start cell, pending none, show_square 0, RGB_out 0, oMoved 0.
- Reset asserted mid-frame overrides any pending move and any commit in that cycle.

Test Plan:
- Reset with all buttons high, release, hold 100 cycles -> oPosX=3, oPosY=4, oMoved never pulses.
- Start (3,4): pulse button_right, then iFrameStart -> oPosX=4. oMoved pulses one cycle. show_square=1 for iReadCol 364..454 with iReadRow 272..339, and 0 at column 363 and 455.
- WRAP=0 at oPosX=0: left edge then iFrameStart -> oPosX stays 0, oMoved stays 0. WRAP=1: same stimulus gives oPosX=6 and bounds 546..636; pixels 637..639 are never shown.
- Up and down edges in the same cycle, then iFrameStart -> oPosY unchanged. Then up, then down in separate cycles, then iFrameStart -> oPosY=5 (latest wins).
- Three right edges within one frame, then iFrameStart -> oPosX advances by exactly 1. An edge coincident with iFrameStart is applied at the next iFrameStart.
- Sweep a full frame with the pixel counters -> show_square is high for exactly CELL_W*CELL_H = 91*68 = 6188 cycles, lagging by 1 cycle. RGB_out = 3'b100 on exactly those cycles.
